palette_lookup_arbiter: RTL and testbench

// - Shared, writable 4-bit-index -> 12-bit RGB palette store for all sprite drawers (players, ball, HUD).
// - Round-robin arbitrates NREQ requesters onto one lookup per cycle and returns RGB through a 2-stage pipeline.
// - Config port lets game logic recolour palettes at run time. Sits between sprite ROM readers and the VGA colour mux.

---
 rtl/palette_lookup_arbiter.sv | 98 +++++++++
 tb/tb_palette_lookup_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/palette_lookup_arbiter.sv
// palette_lookup_arbiter: round-robin shared 16-entry RGB palette lookup with 2-stage response pipeline.
// Optional macro TRANSPARENT_KEY_EN builds the pipelined index-0 transparency flag.
module palette_lookup_arbiter #(
   parameter int NREQ = 4,
   parameter int NPAL = 4,
   localparam int IDW = $clog2(NREQ),
   localparam int PSW = (NPAL > 1) ? $clog2(NPAL) : 1
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic [NREQ-1:0]   req_i,
   input  logic [NREQ*PSW-1:0] req_pal_i,
   input  logic [NREQ*4-1:0] req_idx_i,
   output logic [NREQ-1:0]   gnt_o,
   output logic              rsp_valid_o,
   output logic [IDW-1:0]    rsp_id_o,
   output logic [11:0]       rsp_rgb_o,
   output logic              rsp_transparent_o,
   input  logic              cfg_we_i,
   input  logic [PSW-1:0]    cfg_pal_i,
   input  logic [3:0]        cfg_idx_i,
   input  logic [11:0]       cfg_rgb_i
);
   // Entry 0 is the low slice; entries 7..15 are black.
   localparam logic [191:0] DFLT = {108'h0, 12'hF40, 12'hFF0, 12'h942, 12'hFFF,
                                    12'h000, 12'hF0B, 12'hF00};
   logic [IDW-1:0] ptr_q, ptr_d, gid, k;
   logic           found;
   logic           v1_q;
   logic [IDW-1:0] id1_q;
   logic [PSW-1:0] pal1_q;
   logic [3:0]     idx1_q;
   logic [11:0]    pal_q [NPAL][16];
   logic           rsp_valid_q;
   logic [IDW-1:0] rsp_id_q;
   logic [11:0]    rsp_rgb_q, rgb_d;

   always_comb begin
      found = 1'b0;
      gid   = '0;
      k     = '0;
      for (int i = 0; i < NREQ; i++) begin
         k = IDW'((int'(ptr_q) + i) % NREQ);
         if (!found && req_i[k]) begin
            found = 1'b1;
            gid   = k;
         end
      end
      gnt_o = found ? (NREQ'(1) << gid) : '0;
      ptr_d = !found ? ptr_q : (int'(gid) == NREQ - 1) ? '0 : gid + 1'b1;
      rgb_d = (int'(pal1_q) < NPAL) ? pal_q[pal1_q][idx1_q] : 12'h000;
   end

   // Stage-2 read and config write share an edge, so a colliding read sees the old colour.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         ptr_q       <= '0;
         v1_q        <= 1'b0;
         id1_q       <= '0;
         pal1_q      <= '0;
         idx1_q      <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_rgb_q   <= '0;
         for (int p = 0; p < NPAL; p++)
            for (int e = 0; e < 16; e++)
               pal_q[p][e] <= DFLT[e*12 +: 12];
      end else begin
         ptr_q       <= ptr_d;
         v1_q        <= found;
         id1_q       <= gid;
         pal1_q      <= req_pal_i[int'(gid)*PSW +: PSW];
         idx1_q      <= req_idx_i[int'(gid)*4 +: 4];
         rsp_valid_q <= v1_q;
         if (v1_q) begin
            rsp_id_q  <= id1_q;
            rsp_rgb_q <= rgb_d;
         end
         if (cfg_we_i && int'(cfg_pal_i) < NPAL)
            pal_q[cfg_pal_i][cfg_idx_i] <= cfg_rgb_i;
      end
   end

   assign rsp_valid_o = rsp_valid_q;
   assign rsp_id_o    = rsp_id_q;
   assign rsp_rgb_o   = rsp_rgb_q;

`ifdef TRANSPARENT_KEY_EN
   logic tr_q;
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) tr_q <= 1'b0;
      else if (v1_q) tr_q <= (idx1_q == 4'd0);
   end
   assign rsp_transparent_o = tr_q;
`else
   assign rsp_transparent_o = 1'b0;
`endif
endmodule

// File: tb/tb_palette_lookup_arbiter.sv
// tb_palette_lookup_arbiter: scoreboard bench for the palette lookup arbiter.
module tb_palette_lookup_arbiter;
`ifdef TRANSPARENT_KEY_EN
   localparam bit TR = 1'b1;
`else
   localparam bit TR = 1'b0;
`endif
   logic        clk, reset;
   logic [3:0]  req, gnt;
   logic [7:0]  req_pal;
   logic [15:0] req_idx;
   logic        rsp_valid, rsp_transparent;
   logic [1:0]  rsp_id;
   logic [11:0] rsp_rgb;
   logic        cfg_we;
   logic [1:0]  cfg_pal;
   logic [3:0]  cfg_idx;
   logic [11:0] cfg_rgb;

   typedef struct {
      logic [1:0]  id;
      logic [11:0] rgb;
      logic        tr;
   } sb_t;
   sb_t         sb[$];
   int          n_vec = 0, n_err = 0;
   logic [11:0] m_pal [4][16];
   logic [1:0]  m_ptr, s1id, s1pal;
   logic [3:0]  s1idx;
   logic        s1v;

   palette_lookup_arbiter dut (
      .clk_i(clk), .reset_i(reset), .req_i(req), .req_pal_i(req_pal), .req_idx_i(req_idx),
      .gnt_o(gnt), .rsp_valid_o(rsp_valid), .rsp_id_o(rsp_id), .rsp_rgb_o(rsp_rgb),
      .rsp_transparent_o(rsp_transparent), .cfg_we_i(cfg_we), .cfg_pal_i(cfg_pal),
      .cfg_idx_i(cfg_idx), .cfg_rgb_i(cfg_rgb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [11:0] dflt(input int e);
      case (e)
         0: return 12'hF00;
         1: return 12'hF0B;
         3: return 12'hFFF;
         4: return 12'h942;
         5: return 12'hFF0;
         6: return 12'hF40;
         default: return 12'h000;
      endcase
   endfunction

   task automatic model_reset();
      sb.delete();
      s1v   = 1'b0;
      m_ptr = 2'd0;
      for (int p = 0; p < 4; p++)
         for (int e = 0; e < 16; e++)
            m_pal[p][e] = dflt(e);
   endtask

   // One clock: check and advance the reference model at the falling edge.
   task automatic tick();
      logic [3:0] eg;
      logic [1:0] g, k;
      sb_t        e;
      @(negedge clk);
      if (reset) model_reset();
      eg = 4'd0;
      g  = 2'd0;
      for (int i = 0; i < 4; i++) begin
         k = 2'(m_ptr + 2'(i));
         if (eg == 4'd0 && req[k]) begin
            g  = k;
            eg = 4'b1 << k;
         end
      end
      check("gnt", 32'(gnt), 32'(eg));
      check("rsp_valid", 32'(rsp_valid), 32'(sb.size() != 0));
      if (rsp_valid && sb.size() != 0) begin
         e = sb.pop_front();
         check("rsp_id", 32'(rsp_id), 32'(e.id));
         check("rsp_rgb", 32'(rsp_rgb), 32'(e.rgb));
         check("rsp_transparent", 32'(rsp_transparent), 32'(e.tr));
      end
      if (!reset) begin
         if (s1v) begin
            e.id  = s1id;
            e.rgb = m_pal[s1pal][s1idx];
            e.tr  = TR && (s1idx == 4'd0);
            sb.push_back(e);
         end
         if (cfg_we) m_pal[cfg_pal][cfg_idx] = cfg_rgb;
         s1v   = |req;
         s1id  = g;
         s1pal = req_pal[g*2 +: 2];
         s1idx = req_idx[g*4 +: 4];
         if (|req) m_ptr = g + 2'd1;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; req = '0; req_pal = '0; req_idx = '0;
      cfg_we = 1'b0; cfg_pal = '0; cfg_idx = '0; cfg_rgb = '0;
      model_reset();
      repeat (2) tick();
      check("rst_valid", 32'(rsp_valid), 32'd0);
      check("rst_id", 32'(rsp_id), 32'd0);
      check("rst_rgb", 32'(rsp_rgb), 32'd0);
      check("rst_tr", 32'(rsp_transparent), 32'd0);
      reset = 1'b0;
      // single lookup, latency and hold
      req = 4'b0001; req_idx = 16'h0004;
      #1 check("t1_gnt", 32'(gnt), 32'b0001);
      tick();
      req = '0;
      tick();
      check("t1_valid", 32'(rsp_valid), 32'd1);
      check("t1_rgb", 32'(rsp_rgb), 32'h942);
      tick();
      check("t1_hold", 32'(rsp_rgb), 32'h942);
      reset = 1'b1; tick(); reset = 1'b0;
      // all requesters held: strict rotation
      req = 4'b1111; req_idx = 16'h3333;
      for (int c = 0; c < 6; c++) begin
         #1 check("t2_gnt", 32'(gnt), 32'(4'b0001 << (c % 4)));
         tick();
      end
      req = '0;
      repeat (3) tick();
      // config write colliding with a stage-2 read
      req = 4'b0010; req_pal = 8'b0000_0100; req_idx = 16'h0050;
      tick();
      req = '0; cfg_we = 1'b1; cfg_pal = 2'd1; cfg_idx = 4'd5; cfg_rgb = 12'h0AF;
      tick();
      cfg_we = 1'b0;
      check("t3_old", 32'(rsp_rgb), 32'hFF0);
      req = 4'b0010;
      tick();
      req = '0;
      tick();
      check("t3_new", 32'(rsp_rgb), 32'h0AF);
      tick();
      // index 0 lookup
      req = 4'b0100; req_pal = '0; req_idx = '0;
      tick();
      req = '0;
      tick();
      check("t4_rgb", 32'(rsp_rgb), 32'hF00);
      check("t4_tr", 32'(rsp_transparent), 32'(TR));
      tick();
      // reset mid-stream discards in-flight lookups
      req = 4'b0001;
      tick();
      reset = 1'b1;
      repeat (2) tick();
      reset = 1'b0; req = '0;
      repeat (4) begin
         check("t5_quiet", 32'(rsp_valid), 32'd0);
         tick();
      end
      req = 4'b1010;
      #1 check("t5_gnt", 32'(gnt), 32'b0010);
      tick();
      req = '0;
      repeat (3) tick();
      // reset restores default palette
      cfg_we = 1'b1; cfg_pal = 2'd2; cfg_idx = 4'd6; cfg_rgb = 12'h123;
      tick();
      cfg_we = 1'b0; reset = 1'b1;
      tick();
      reset = 1'b0; req = 4'b0001; req_pal = 8'h02; req_idx = 16'h0006;
      tick();
      req = '0;
      tick();
      check("t6_rgb", 32'(rsp_rgb), 32'hF40);
      // lone requester is granted every cycle
      req = 4'b0001;
      repeat (4) begin
         #1 check("hog_gnt", 32'(gnt), 32'b0001);
         tick();
      end
      req = '0;
      repeat (3) tick();
      // random traffic with config writes
      for (int c = 0; c < 300; c++) begin
         req     = 4'($urandom);
         req_pal = 8'($urandom);
         req_idx = 16'($urandom);
         cfg_we  = ($urandom_range(3) == 0);
         cfg_pal = 2'($urandom);
         cfg_idx = 4'($urandom);
         cfg_rgb = 12'($urandom);
         tick();
      end
      req = '0; cfg_we = 1'b0;
      repeat (3) tick();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
